uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with TX FIFO and run-time parity / stop-bit selection.
// Ports: clk, reset (sync, active high), s_valid/s_data/s_ready write side,
//   parity_mode (00 none, 01 even, 10 odd, 11 none), two_stop,
//   tx (idle high), busy, done (end-of-frame pulse), fifo_count.
module uart_tx_cfg #(
  parameter int DATA_BITS     = 8,
  parameter int CLKS_PER_BAUD = 55,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [NW-1:0]        cnt_fifo_q;

  state_e               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q, par_en_q, two_q;
  logic                 tx_q, tx_d;
  logic                 busy_q, done_q, done_d;

  logic                 push, pop, empty, baud_end;
  logic [DATA_BITS-1:0] head;

  assign empty    = (cnt_fifo_q == '0);
  assign s_ready  = (cnt_fifo_q < NW'(FIFO_DEPTH));
  assign push     = s_valid & s_ready;
  assign head     = mem_q[rd_q];
  assign baud_end = (baud_q == CW'(CLKS_PER_BAUD - 1));

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = cnt_fifo_q;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_q] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_fifo_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_fifo_q <= cnt_fifo_q + 1'b1;
        2'b01:   cnt_fifo_q <= cnt_fifo_q - 1'b1;
        default: cnt_fifo_q <= cnt_fifo_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = sh_q[0];
        if (baud_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        tx_d = par_q;
        if (baud_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (two_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d = 1'b1;
            bit_d  = '0;
            // Chain straight into the next frame when data is waiting.
            if (!empty) begin
              state_d = START;
              pop     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so tx/busy/done
  // trail the FSM by one cycle and stay mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      two_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE);
      done_q  <= done_d;
      if (pop) begin
        sh_q     <= head;
        par_q    <= (^head) ^ (parity_mode == 2'b10);
        par_en_q <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        two_q    <= two_stop;
      end else if (state_q == DATA && baud_end) begin
        sh_q <= sh_q >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (default parameters).
// Frames are captured cycle by cycle and compared to hand-built bit images.
module tb_uart_tx_cfg;

  localparam int CPB = 55;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;

  uart_tx_cfg #(
    .DATA_BITS(8),
    .CLKS_PER_BAUD(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .parity_mode(parity_mode),
    .two_stop(two_stop),
    .tx(tx),
    .busy(busy),
    .done(done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic [7:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    acc     = cyc;
    s_valid = 1'b0;
  endtask

  // Waits for a start bit, then records nb bit periods cycle by cycle.
  task automatic capture(input int nb, output logic [15:0] bits,
                         output int st, output int dpos,
                         output int dcnt, output int glitch,
                         output int nbusy);
    bits = '0; st = -1; dpos = -1; dcnt = 0; glitch = 0; nbusy = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        break;
      end
    end
    if (st >= 0) begin
      for (int i = 0; i < nb; i++) begin
        for (int j = 0; j < CPB; j++) begin
          if (!(i == 0 && j == 0)) @(negedge clk);
          if (j == 0) bits[i] = tx;
          else if (tx !== bits[i]) glitch++;
          if (done === 1'b1) begin
            dcnt++;
            dpos = i * CPB + j;
          end
          if (busy !== 1'b1) nbusy++;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx, busy, done, s_ready, fifo_count} !== 7'b1001_000) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b done=%b rdy=%b cnt=%0d",
               tx, busy, done, s_ready, fifo_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_8n1();
    logic [15:0] b;
    int st, dp, dc, gl, nb;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      drive(8'h55);
      capture(10, b, st, dp, dc, gl, nb);
    join
    checks++;
    if (st !== acc + 2) begin
      errors++;
      $display("FAIL 8n1_latency: start=%0d required %0d", st, acc + 2);
    end
    checks++;
    if (b[9:0] !== 10'h2AA) begin
      errors++;
      $display("FAIL 8n1_bits: got %h required 2aa", b[9:0]);
    end
    checks++;
    if (gl !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL 8n1_width: glitch=%0d notbusy=%0d required 0", gl, nb);
    end
    checks++;
    if (dc !== 1 || dp !== 10 * CPB - 1) begin
      errors++;
      $display("FAIL 8n1_done: cnt=%0d pos=%0d required 1/%0d",
               dc, dp, 10 * CPB - 1);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL 8n1_idle: tx=%b busy=%b cnt=%0d required 1/0/0",
               tx, busy, fifo_count);
    end
  endtask

  task automatic test_parity_toggle();
    logic [15:0] b1, b2;
    int s1, d1, c1, g1, n1, s2, d2, c2, g2, n2;
    parity_mode = 2'b01;
    two_stop    = 1'b0;
    drive(8'h07);
    drive(8'h07);
    fork
      begin
        repeat (100) @(negedge clk);
        parity_mode = 2'b10;
      end
      begin
        capture(11, b1, s1, d1, c1, g1, n1);
        capture(11, b2, s2, d2, c2, g2, n2);
      end
    join
    checks++;
    if (b1[10:0] !== 11'h60E) begin
      errors++;
      $display("FAIL par_even: got %h required 60e", b1[10:0]);
    end
    checks++;
    if (b2[10:0] !== 11'h40E) begin
      errors++;
      $display("FAIL par_odd: got %h required 40e", b2[10:0]);
    end
    checks++;
    if (d1 !== 11 * CPB - 1 || c1 !== 1 || g1 !== 0) begin
      errors++;
      $display("FAIL par_len: pos=%0d cnt=%0d glitch=%0d required %0d/1/0",
               d1, c1, g1, 11 * CPB - 1);
    end
    checks++;
    if (s2 - s1 !== 11 * CPB) begin
      errors++;
      $display("FAIL par_gap: delta=%0d required %0d", s2 - s1, 11 * CPB);
    end
    wait_idle();
    parity_mode = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [15:0] b [3];
    int s [3];
    int d [3];
    int c [3];
    int g [3];
    int n [3];
    logic [10:0] exp_b [3];
    exp_b[0] = 11'h662;
    exp_b[1] = 11'h790;
    exp_b[2] = 11'h61E;
    parity_mode = 2'b00;
    two_stop    = 1'b1;
    fork
      begin
        drive(8'h31);
        drive(8'hC8);
        drive(8'h0F);
      end
      for (int i = 0; i < 3; i++) begin
        capture(11, b[i], s[i], d[i], c[i], g[i], n[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b[i][10:0] !== exp_b[i] || g[i] !== 0 || c[i] !== 1) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h glitch=%0d done=%0d required %h/0/1",
                 i, b[i][10:0], g[i], c[i], exp_b[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if ((s[i] + d[i]) - (s[i-1] + d[i-1]) !== 605 || s[i] - s[i-1] !== 605) begin
        errors++;
        $display("FAIL b2b_spacing%0d: done delta=%0d start delta=%0d required 605",
                 i, (s[i] + d[i]) - (s[i-1] + d[i-1]), s[i] - s[i-1]);
      end
    end
    wait_idle();
    two_stop = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] vals [6];
    logic [15:0] b [5];
    int s [5];
    int d [5];
    int c [5];
    int g [5];
    int n [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    vals[3] = 8'h44; vals[4] = 8'h5A; vals[5] = 8'h66;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        drive(vals[0]);
        drive(vals[1]);
        checks++;
        if (fifo_count !== 3'd1) begin
          errors++;
          $display("FAIL fifo_pushpop: cnt=%0d required 1", fifo_count);
        end
        drive(vals[2]);
        drive(vals[3]);
        drive(vals[4]);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL fifo_full: rdy=%b cnt=%0d required 0/4",
                   s_ready, fifo_count);
        end
        drive(vals[5]);
        checks++;
        if (fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL fifo_overflow: cnt=%0d required 4", fifo_count);
        end
      end
      for (int i = 0; i < 5; i++) begin
        capture(10, b[i], s[i], d[i], c[i], g[i], n[i]);
      end
    join
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b[i][9:0] !== {1'b1, vals[i], 1'b0} || g[i] !== 0) begin
        errors++;
        $display("FAIL fifo_order%0d: got %h required %h",
                 i, b[i][9:0], {1'b1, vals[i], 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drain: busy=%b tx=%b required 0/1", busy, tx);
    end
  endtask

  task automatic test_reset_midframe();
    int lows;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    drive(8'hA5);
    drive(8'h01);
    drive(8'h02);
    drive(8'h03);
    repeat (CPB + 30) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: busy=%b cnt=%0d required 1/3", busy, fifo_count);
    end
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: tx=%b busy=%b cnt=%0d done=%b required 1/0/0/0",
               tx, busy, fifo_count, done);
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    lows    = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL rst_quiet: active cycles=%0d required 0", lows);
    end
  endtask

  initial begin
    reset       = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    test_reset();
    test_8n1();
    test_parity_toggle();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
